// File: rtl/cpu_pkg.sv
// Shared CPU types: datapath widths, execute-unit state encoding and the
// prioritised operation code derived from the decoder's one-hot strobes.
package cpu_pkg;

  localparam int DWIDTH = 16;
  localparam int AWIDTH = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_RD,
    ST_EXEC,
    ST_MEM_WR,
    ST_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_ADD,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH,
    OP_ISZ,
    OP_CLR_AC,
    OP_CLR_E,
    OP_COMP_AC,
    OP_LOAD_AC,
    OP_CIR_R,
    OP_CIR_L,
    OP_INC_AC
  } op_t;

  // strobes[11] is add (highest priority) down to strobes[0] inc_ac; the
  // ascending scan lets the highest set bit overwrite any lower one.
  function automatic op_t pick_op(input logic [11:0] strobes);
    op_t r;
    r = OP_NOP;
    for (int i = 0; i < 12; i++) begin
      if (strobes[i]) r = op_t'(4'(12 - i));
    end
    return r;
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Memory request/response bus between the execute unit (master) and the
// data memory (slave).
interface exec_unit_if #(
  parameter int DWIDTH = cpu_pkg::DWIDTH,
  parameter int AWIDTH = cpu_pkg::AWIDTH
);
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/exec_unit_alu.sv
// Combinational AC/E update for the EXEC state, plus the ISZ increment of DR
// and its wrap-to-zero flag.
module exec_alu
  import cpu_pkg::*;
(
  input  op_t               op,
  input  logic [DWIDTH-1:0] ac,
  input  logic              e,
  input  logic [DWIDTH-1:0] dr,
  input  logic [7:0]        imm,
  output logic [DWIDTH-1:0] ac_next,
  output logic              e_next,
  output logic [DWIDTH-1:0] dr_inc,
  output logic              isz_zero
);

  always_comb begin
    ac_next = ac;
    e_next  = e;
    case (op)
      OP_ADD:     {e_next, ac_next} = {1'b0, ac} + {1'b0, dr};
      OP_LOAD:    ac_next = dr;
      OP_CLR_AC:  ac_next = '0;
      OP_CLR_E:   e_next = 1'b0;
      OP_COMP_AC: ac_next = ~ac;
      OP_LOAD_AC: ac_next = {{(DWIDTH-8){1'b0}}, imm};
      OP_CIR_R: begin
        ac_next = {e, ac[DWIDTH-1:1]};
        e_next  = ac[0];
      end
      OP_CIR_L: begin
        ac_next = {ac[DWIDTH-2:0], e};
        e_next  = ac[DWIDTH-1];
      end
      OP_INC_AC:  ac_next = ac + DWIDTH'(1);
      default:    ;
    endcase
  end

  assign dr_inc   = dr + DWIDTH'(1);
  assign isz_zero = (dr_inc == '0);

endmodule

// File: rtl/exec_unit.sv
// Execute datapath: AC/E/DR registers, memory handshake FSM and completion
// pulse. Define MEM_TIMEOUT_EN to abort memory waits after TIMEOUT_CYCLES.
module exec_unit #(
  parameter int DWIDTH         = cpu_pkg::DWIDTH,
  parameter int AWIDTH         = cpu_pkg::AWIDTH,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_execute,
  input  logic              i_add,
  input  logic              i_load,
  input  logic              i_store,
  input  logic              i_branch,
  input  logic              i_isz,
  input  logic              i_clr_ac,
  input  logic              i_clr_e,
  input  logic              i_comp_ac,
  input  logic              i_load_ac,
  input  logic              i_cir_r,
  input  logic              i_cir_l,
  input  logic              i_inc_ac,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [7:0]        i_imm,
  exec_unit_if.master       mem,
  output logic [DWIDTH-1:0] o_ac,
  output logic              o_e,
  output logic              o_pc_load,
  output logic [AWIDTH-1:0] o_pc_val,
  output logic              o_pc_skip,
  output logic              o_ex_done,
  output logic              o_ex_err
);
  import cpu_pkg::*;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("exec_unit: TIMEOUT_CYCLES must be at least 1");
  end

  state_t            state_reg;
  op_t               op_reg;
  logic [7:0]        imm_reg;
  logic [DWIDTH-1:0] ac_reg;
  logic              e_reg;
  logic [DWIDTH-1:0] dr_reg;
  logic              armed_reg;
  logic              skip_pend_reg;
  logic [AWIDTH-1:0] mem_addr_reg;
  logic              mem_rd_reg;
  logic              mem_wr_reg;
  logic [DWIDTH-1:0] mem_wdata_reg;
  logic              pc_load_reg;
  logic [AWIDTH-1:0] pc_val_reg;
  logic              pc_skip_reg;
  logic              ex_done_reg;

  op_t               op_sel;
  logic [DWIDTH-1:0] ac_next;
  logic              e_next;
  logic [DWIDTH-1:0] dr_inc;
  logic              isz_zero;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcount_reg;
  logic          ex_err_reg;
  logic          tout_hit;
  assign tout_hit = (tcount_reg == TW'(TIMEOUT_CYCLES - 1));
  assign o_ex_err = ex_err_reg;
`else
  assign o_ex_err = 1'b0;
`endif

  assign op_sel = pick_op({i_add, i_load, i_store, i_branch, i_isz, i_clr_ac,
                           i_clr_e, i_comp_ac, i_load_ac, i_cir_r, i_cir_l,
                           i_inc_ac});

  exec_alu u_alu (
    .op       (op_reg),
    .ac       (ac_reg),
    .e        (e_reg),
    .dr       (dr_reg),
    .imm      (imm_reg),
    .ac_next  (ac_next),
    .e_next   (e_next),
    .dr_inc   (dr_inc),
    .isz_zero (isz_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_NOP;
      imm_reg       <= '0;
      ac_reg        <= '0;
      e_reg         <= 1'b0;
      dr_reg        <= '0;
      armed_reg     <= 1'b1;
      skip_pend_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_rd_reg    <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_wdata_reg <= '0;
      pc_load_reg   <= 1'b0;
      pc_val_reg    <= '0;
      pc_skip_reg   <= 1'b0;
      ex_done_reg   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tcount_reg    <= '0;
      ex_err_reg    <= 1'b0;
`endif
    end else begin
      ex_done_reg <= 1'b0;
      pc_load_reg <= 1'b0;
      pc_skip_reg <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      ex_err_reg  <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (!i_execute) armed_reg <= 1'b1;
          if (i_execute && armed_reg) begin
            op_reg  <= op_sel;
            imm_reg <= i_imm;
`ifdef MEM_TIMEOUT_EN
            tcount_reg <= '0;
`endif
            case (op_sel)
              OP_ADD, OP_LOAD, OP_ISZ: begin
                state_reg    <= ST_MEM_RD;
                mem_rd_reg   <= 1'b1;
                mem_addr_reg <= i_addr;
              end
              OP_STORE: begin
                state_reg     <= ST_MEM_WR;
                mem_wr_reg    <= 1'b1;
                mem_addr_reg  <= i_addr;
                mem_wdata_reg <= ac_reg;
              end
              OP_BRANCH: begin
                state_reg   <= ST_EXEC;
                pc_load_reg <= 1'b1;
                pc_val_reg  <= i_addr;
              end
              OP_NOP: begin
                state_reg   <= ST_DONE;
                ex_done_reg <= 1'b1;
              end
              default: state_reg <= ST_EXEC;
            endcase
          end
        end

        ST_MEM_RD: begin
          if (mem.mem_ready) begin
            dr_reg     <= mem.mem_rdata;
            mem_rd_reg <= 1'b0;
            state_reg  <= ST_EXEC;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tout_hit) begin
            mem_rd_reg  <= 1'b0;
            state_reg   <= ST_DONE;
            ex_done_reg <= 1'b1;
            ex_err_reg  <= 1'b1;
          end else begin
            tcount_reg <= tcount_reg + TW'(1);
          end
`endif
        end

        ST_EXEC: begin
          ac_reg <= ac_next;
          e_reg  <= e_next;
          if (op_reg == OP_ISZ) begin
            // Write back the incremented word; the skip is only released
            // once the memory has accepted that write.
            dr_reg        <= dr_inc;
            skip_pend_reg <= isz_zero;
            mem_wr_reg    <= 1'b1;
            mem_wdata_reg <= dr_inc;
            state_reg     <= ST_MEM_WR;
`ifdef MEM_TIMEOUT_EN
            tcount_reg    <= '0;
`endif
          end else begin
            state_reg   <= ST_DONE;
            ex_done_reg <= 1'b1;
          end
        end

        ST_MEM_WR: begin
          if (mem.mem_ready) begin
            mem_wr_reg  <= 1'b0;
            state_reg   <= ST_DONE;
            ex_done_reg <= 1'b1;
            pc_skip_reg <= skip_pend_reg;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tout_hit) begin
            mem_wr_reg  <= 1'b0;
            state_reg   <= ST_DONE;
            ex_done_reg <= 1'b1;
            ex_err_reg  <= 1'b1;
          end else begin
            tcount_reg <= tcount_reg + TW'(1);
          end
`endif
        end

        ST_DONE: begin
          state_reg     <= ST_IDLE;
          armed_reg     <= !i_execute;
          skip_pend_reg <= 1'b0;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_rd    = mem_rd_reg;
  assign mem.mem_wr    = mem_wr_reg;
  assign mem.mem_wdata = mem_wdata_reg;
  assign o_ac          = ac_reg;
  assign o_e           = e_reg;
  assign o_pc_load     = pc_load_reg;
  assign o_pc_val      = pc_val_reg;
  assign o_pc_skip     = pc_skip_reg;
  assign o_ex_done     = ex_done_reg;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed scenarios plus randomized
// operations against a transaction-level model of AC/E, memory and timing.
module tb_exec_unit;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int TO = 15;

  localparam logic [11:0] S_ADD  = 12'h001, S_LOAD = 12'h002, S_STORE = 12'h004,
                          S_BR   = 12'h008, S_ISZ  = 12'h010, S_CLRAC = 12'h020,
                          S_CLRE = 12'h040, S_COMP = 12'h080, S_LDAC  = 12'h100,
                          S_CIRR = 12'h200, S_CIRL = 12'h400, S_INC   = 12'h800;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          execute = 1'b0;
  logic [11:0]   stb = '0;   // [0]=add ... [11]=inc_ac, lowest index wins
  logic [AW-1:0] addr = '0;
  logic [7:0]    imm = '0;
  logic [DW-1:0] ac;
  logic          e, pc_load, pc_skip, ex_done, ex_err;
  logic [AW-1:0] pc_val;

  exec_unit_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  exec_unit #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .i_execute(execute),
    .i_add(stb[0]), .i_load(stb[1]), .i_store(stb[2]), .i_branch(stb[3]),
    .i_isz(stb[4]), .i_clr_ac(stb[5]), .i_clr_e(stb[6]), .i_comp_ac(stb[7]),
    .i_load_ac(stb[8]), .i_cir_r(stb[9]), .i_cir_l(stb[10]), .i_inc_ac(stb[11]),
    .i_addr(addr), .i_imm(imm), .mem(bus.master),
    .o_ac(ac), .o_e(e), .o_pc_load(pc_load), .o_pc_val(pc_val),
    .o_pc_skip(pc_skip), .o_ex_done(ex_done), .o_ex_err(ex_err)
  );

  // Memory with a programmable number of wait cycles per request.
  logic [DW-1:0] mem [0:4095];
  int  cfg_wait = 0;
  bit  req_seen = 0;
  int  waits_left = 0;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(negedge clk) begin
    if (bus.mem_rd || bus.mem_wr) begin
      if (!req_seen) begin
        req_seen = 1;
        waits_left = cfg_wait;
      end
      if (waits_left == 0) bus.mem_ready = 1'b1;
      else begin
        bus.mem_ready = 1'b0;
        waits_left--;
      end
    end else begin
      req_seen = 0;
      bus.mem_ready = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (bus.mem_wr && bus.mem_ready) mem[bus.mem_addr] = bus.mem_wdata;
  end

  // Reference model state and expected timeline of the current operation.
  logic [DW-1:0] m_mem [0:4095];
  logic [DW-1:0] m_ac = '0;
  logic          m_e = 1'b0;
  int checks = 0, errors = 0;
  int cyc = 0;
  bit active = 0;
  int rd_lo, rd_hi, wr_lo, wr_hi, pcl_cyc, exp_done;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_ac;
  logic          exp_e, exp_skip, exp_err;
  int  last_done_cyc;
  bit  last_skip;
  logic [AW-1:0] last_pc_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h want %0h", name, cyc, act, want);
    end
  endtask

  task automatic set_mem(input logic [AW-1:0] a, input logic [DW-1:0] v);
    mem[a] = v;
    m_mem[a] = v;
  endtask

  task automatic model_op(input logic [11:0] s, input logic [AW-1:0] a,
                          input logic [7:0] im, input int w);
    int op;
    bit tout;
    logic [DW:0] sum;
    logic [DW-1:0] v;
    op = -1;
    for (int i = 0; i < 12; i++) if (s[i] && op < 0) op = i;
    rd_lo = 1; rd_hi = 0; wr_lo = 1; wr_hi = 0; pcl_cyc = -1;
    exp_skip = 0; exp_err = 0; exp_addr = a; exp_wdata = '0;
`ifdef MEM_TIMEOUT_EN
    tout = (w >= TO);
`else
    tout = 0;
`endif
    if (tout && (op == 0 || op == 1 || op == 4)) begin
      rd_hi = TO; exp_done = TO + 1; exp_err = 1;
    end else if (tout && op == 2) begin
      wr_hi = TO; exp_done = TO + 1; exp_err = 1;
    end else begin
      case (op)
        0, 1: begin
          rd_hi = 1 + w; exp_done = 3 + w;
          if (op == 0) begin
            sum = {1'b0, m_ac} + {1'b0, m_mem[a]};
            m_ac = sum[DW-1:0];
            m_e = sum[DW];
          end else m_ac = m_mem[a];
        end
        2: begin
          wr_hi = 1 + w; exp_done = 2 + w;
          exp_wdata = m_ac; m_mem[a] = m_ac;
        end
        3: begin pcl_cyc = 1; exp_done = 2; end
        4: begin
          rd_hi = 1 + w; wr_lo = 3 + w; wr_hi = 3 + 2 * w; exp_done = 4 + 2 * w;
          v = m_mem[a] + 1'b1;
          exp_wdata = v; m_mem[a] = v; exp_skip = (v == 0);
        end
        5: begin m_ac = 0; exp_done = 2; end
        6: begin m_e = 0; exp_done = 2; end
        7: begin m_ac = ~m_ac; exp_done = 2; end
        8: begin m_ac = {8'h00, im}; exp_done = 2; end
        9: begin
          v = (m_ac >> 1) | (DW'(m_e) << (DW - 1));
          m_e = m_ac[0]; m_ac = v; exp_done = 2;
        end
        10: begin
          v = (m_ac << 1) | DW'(m_e);
          m_e = m_ac[DW-1]; m_ac = v; exp_done = 2;
        end
        11: begin m_ac = m_ac + 1'b1; exp_done = 2; end
        default: exp_done = 1;
      endcase
    end
    exp_ac = m_ac;
    exp_e = m_e;
  endtask

  // Per-cycle comparison against the expected timeline.
  always @(negedge clk) begin
    if (active) begin
      cyc++;
      chk("mem_rd", bus.mem_rd, (cyc >= rd_lo && cyc <= rd_hi));
      chk("mem_wr", bus.mem_wr, (cyc >= wr_lo && cyc <= wr_hi));
      chk("ex_done", ex_done, cyc == exp_done);
      chk("pc_load", pc_load, cyc == pcl_cyc);
      chk("pc_skip", pc_skip, (cyc == exp_done) && exp_skip);
      chk("ex_err", ex_err, (cyc == exp_done) && exp_err);
      if (bus.mem_rd || bus.mem_wr) chk("mem_addr", bus.mem_addr, exp_addr);
      if (bus.mem_wr) chk("mem_wdata", bus.mem_wdata, exp_wdata);
      if (pc_load) begin
        chk("pc_val", pc_val, exp_addr);
        last_pc_val = pc_val;
      end
      if (ex_done) begin
        last_done_cyc = cyc;
        last_skip = pc_skip;
      end
      if (cyc == exp_done) begin
        chk("ac", ac, exp_ac);
        chk("e", e, exp_e);
      end
    end
  end

  task automatic do_op(input logic [11:0] s, input logic [AW-1:0] a,
                       input logic [7:0] im, input int w, input bit hold);
    int extra;
    extra = hold ? 6 : 0;
    cfg_wait = w;
    model_op(s, a, im, w);
    @(negedge clk);
    stb = s; addr = a; imm = im; execute = 1'b1;
    @(posedge clk);
    cyc = 0;
    active = 1;
    @(negedge clk);
    #1;
    stb = 12'($urandom);
    addr = AW'($urandom);
    if (!hold) execute = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (cyc > exp_done + extra) break;
      @(negedge clk);
      #1;
    end
    if (cyc <= exp_done + extra) begin
      checks++; errors++;
      $display("FAIL op_wait cyc=%0d got no completion want done by %0d", cyc, exp_done);
    end
    active = 0;
    if (hold) begin
      execute = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) set_mem(AW'(i), DW'($urandom));
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ac", ac, 0);
    chk("rst_e", e, 0);
    chk("rst_rd", bus.mem_rd, 0);
    chk("rst_wr", bus.mem_wr, 0);
    chk("rst_done", ex_done, 0);
    chk("rst_pc_load", pc_load, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // cir_r from AC=1234, E=1
    set_mem(12'h011, 16'hFFFF);
    set_mem(12'h012, 16'h0001);
    set_mem(12'h010, 16'h1234);
    do_op(S_LOAD, 12'h011, 8'h00, 0, 0);
    do_op(S_ADD, 12'h012, 8'h00, 0, 0);
    do_op(S_LOAD, 12'h010, 8'h00, 1, 0);
    do_op(S_CIRR, 12'h000, 8'h00, 0, 0);
    chk("lit_cir_ac", ac, 16'h891A);
    chk("lit_cir_e", e, 0);
    chk("lit_cir_done_cyc", last_done_cyc, 2);

    // add with two wait states
    set_mem(12'h013, 16'hFFFF);
    set_mem(12'h050, 16'h0002);
    do_op(S_LOAD, 12'h013, 8'h00, 0, 0);
    do_op(S_ADD, 12'h050, 8'h00, 2, 0);
    chk("lit_add_ac", ac, 16'h0001);
    chk("lit_add_e", e, 1);
    chk("lit_add_done_cyc", last_done_cyc, 5);

    // isz wrap to zero
    set_mem(12'h0A0, 16'hFFFF);
    do_op(S_ISZ, 12'h0A0, 8'h00, 0, 0);
    chk("lit_isz_mem", mem[12'h0A0], 16'h0000);
    chk("lit_isz_skip", last_skip, 1);
    chk("lit_isz_ac", ac, 16'h0001);
    chk("lit_isz_done_cyc", last_done_cyc, 4);

    // store then branch
    set_mem(12'h014, 16'hBEEF);
    do_op(S_LOAD, 12'h014, 8'h00, 0, 0);
    do_op(S_STORE, 12'h123, 8'h00, 0, 0);
    chk("lit_store_mem", mem[12'h123], 16'hBEEF);
    do_op(S_BR, 12'h200, 8'h00, 0, 0);
    chk("lit_branch_pc", last_pc_val, 12'h200);

    // execute held high, priority with several strobes, no-op
    do_op(S_INC, 12'h000, 8'h00, 0, 1);
    chk("lit_inc_ac", ac, 16'hBEF0);
    do_op(S_LDAC | S_CLRAC | S_INC, 12'h000, 8'h77, 0, 0);
    chk("lit_prio_ac", ac, 16'h0000);
    do_op(12'h000, 12'h000, 8'h00, 0, 0);
    do_op(S_LDAC, 12'h000, 8'h5A, 0, 0);

`ifdef MEM_TIMEOUT_EN
    do_op(S_ADD, 12'h050, 8'h00, 20, 0);
    chk("lit_tout_ac", ac, 16'h005A);
    do_op(S_ISZ, 12'h0A0, 8'h00, 20, 0);
    chk("lit_tout_mem", mem[12'h0A0], 16'h0000);
    do_op(S_STORE, 12'h0A1, 8'h00, 20, 0);
`endif

    // reset during a read wait
    cfg_wait = 10;
    @(negedge clk);
    stb = S_ADD; addr = 12'h050; execute = 1'b1;
    @(negedge clk);
    execute = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_rd_before", bus.mem_rd, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_rd", bus.mem_rd, 0);
    chk("rstmid_ac", ac, 0);
    chk("rstmid_e", e, 0);
    chk("rstmid_done", ex_done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_ac = '0;
    m_e = 1'b0;
    do_op(S_LDAC, 12'h000, 8'hC3, 0, 0);

    for (int n = 0; n < 200; n++) begin
      logic [11:0] s;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) s = '0;
      else if (r < 3) s = 12'($urandom);
      else s = 12'(1) << $urandom_range(0, 11);
      do_op(s, AW'($urandom_range(0, 31)), 8'($urandom), $urandom_range(0, 3),
            ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
